// File: rtl/instr_mem_loader.sv
// Loadable instruction memory for the fetch stage.
// Filled word-by-word over a valid/ready port while in LOAD, then serves
// registered one-cycle fetches in RUN. Invalid fetches return NOP_WORD and
// set a sticky fault flag. A fetched HALT_WORD sets a sticky halt flag, and
// every fetch after that returns NOP_WORD.
module instr_mem_loader #(
  parameter int unsigned        DATA_W    = 32,
  parameter int unsigned        DEPTH     = 64,
  parameter int unsigned        ADDR_W    = 32,
  parameter bit                 BYTE_ADDR = 1'b1,
  parameter logic [DATA_W-1:0]  NOP_WORD  = '0,
  parameter logic [DATA_W-1:0]  HALT_WORD = '1
) (
  input  logic                         Clk,
  input  logic                         Rst_n,
  input  logic                         LoadValid,
  input  logic [DATA_W-1:0]            LoadData,
  input  logic                         LoadDone,
  output logic                         LoadReady,
  output logic [$clog2(DEPTH+1)-1:0]   LoadCount,
  output logic                         Running,
  input  logic                         FetchReq,
  input  logic [ADDR_W-1:0]            FetchAddr,
  output logic                         FetchValid,
  output logic [DATA_W-1:0]            InstrOut,
  output logic                         AddrFault,
  output logic                         Halted
);

  localparam int unsigned      CW      = $clog2(DEPTH + 1);
  localparam int unsigned      IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0]    LAST    = CW'(DEPTH - 1);
  localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
  localparam logic [ADDR_W:0]  DEPTH_X = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {
    S_LOAD,
    S_RUN
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [CW-1:0]       load_count;
  logic                load_fire;
  logic [ADDR_W:0]     idx;
  logic                misaligned;
  logic                addr_bad;
  logic [DATA_W-1:0]   rd_word;

  assign LoadCount = load_count;

  // Fetch address decode. The index keeps every upper address bit (plus one
  // guard bit) so large addresses never alias back into the array.
  always_comb begin
    idx        = BYTE_ADDR ? {3'b000, FetchAddr[ADDR_W-1:2]} : {1'b0, FetchAddr};
    misaligned = BYTE_ADDR && (FetchAddr[1:0] != 2'b00);
    addr_bad   = misaligned || (idx >= DEPTH_X) || (idx >= (ADDR_W + 1)'(load_count));
    rd_word    = mem[IW'(idx)];
  end

  // Next-state and load handshake decode.
  always_comb begin
    state_next = state;
    LoadReady  = 1'b0;
    Running    = 1'b0;
    load_fire  = 1'b0;
    case (state)
      S_LOAD: begin
        LoadReady = (load_count < DEPTH_C);
        load_fire = LoadValid && LoadReady;
        if (LoadDone || (load_fire && (load_count == LAST)))
          state_next = S_RUN;
      end
      S_RUN: begin
        Running = 1'b1;
      end
      default: state_next = S_LOAD;
    endcase
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (!Rst_n) state <= S_LOAD;
    else        state <= state_next;
  end

  // Load pointer; frozen outside LOAD.
  always_ff @(posedge Clk) begin
    if (!Rst_n)         load_count <= '0;
    else if (load_fire) load_count <= load_count + 1'b1;
  end

  // Instruction storage; deliberately not reset.
  always_ff @(posedge Clk) begin
    if (load_fire) mem[IW'(load_count)] <= LoadData;
  end

  // Registered fetch port with sticky fault and halt flags.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      FetchValid <= 1'b0;
      InstrOut   <= NOP_WORD;
      AddrFault  <= 1'b0;
      Halted     <= 1'b0;
    end else if ((state == S_RUN) && FetchReq) begin
      FetchValid <= 1'b1;
      if (Halted) begin
        InstrOut <= NOP_WORD;
      end else if (addr_bad) begin
        InstrOut  <= NOP_WORD;
        AddrFault <= 1'b1;
      end else begin
        InstrOut <= rd_word;
        if (rd_word == HALT_WORD) Halted <= 1'b1;
      end
    end else begin
      FetchValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed self-checking bench for instr_mem_loader: default configuration,
// a DEPTH=4 instance for auto-RUN, and a word-addressed instance.
module tb_instr_mem_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Instance A: default parameters
  logic        a_lv = 1'b0, a_done = 1'b0, a_freq = 1'b0;
  logic [31:0] a_ld = '0, a_faddr = '0;
  logic        a_ready, a_run, a_fv, a_fault, a_halt;
  logic [6:0]  a_cnt;
  logic [31:0] a_instr;

  // Instance B: DEPTH=4
  logic        b_lv = 1'b0, b_done = 1'b0, b_freq = 1'b0;
  logic [31:0] b_ld = '0, b_faddr = '0;
  logic        b_ready, b_run, b_fv, b_fault, b_halt;
  logic [2:0]  b_cnt;
  logic [31:0] b_instr;

  // Instance C: word-addressed fetch
  logic        c_lv = 1'b0, c_done = 1'b0, c_freq = 1'b0;
  logic [31:0] c_ld = '0, c_faddr = '0;
  logic        c_ready, c_run, c_fv, c_fault, c_halt;
  logic [6:0]  c_cnt;
  logic [31:0] c_instr;

  instr_mem_loader u_a (
    .Clk(clk), .Rst_n(rst_n), .LoadValid(a_lv), .LoadData(a_ld), .LoadDone(a_done),
    .LoadReady(a_ready), .LoadCount(a_cnt), .Running(a_run), .FetchReq(a_freq),
    .FetchAddr(a_faddr), .FetchValid(a_fv), .InstrOut(a_instr), .AddrFault(a_fault),
    .Halted(a_halt)
  );

  instr_mem_loader #(.DEPTH(4)) u_b (
    .Clk(clk), .Rst_n(rst_n), .LoadValid(b_lv), .LoadData(b_ld), .LoadDone(b_done),
    .LoadReady(b_ready), .LoadCount(b_cnt), .Running(b_run), .FetchReq(b_freq),
    .FetchAddr(b_faddr), .FetchValid(b_fv), .InstrOut(b_instr), .AddrFault(b_fault),
    .Halted(b_halt)
  );

  instr_mem_loader #(.BYTE_ADDR(1'b0)) u_c (
    .Clk(clk), .Rst_n(rst_n), .LoadValid(c_lv), .LoadData(c_ld), .LoadDone(c_done),
    .LoadReady(c_ready), .LoadCount(c_cnt), .Running(c_run), .FetchReq(c_freq),
    .FetchAddr(c_faddr), .FetchValid(c_fv), .InstrOut(c_instr), .AddrFault(c_fault),
    .Halted(c_halt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic a_load(input logic [31:0] w);
    a_lv = 1'b1; a_ld = w; tick(); a_lv = 1'b0;
  endtask

  task automatic a_fetch(input logic [31:0] addr);
    a_freq = 1'b1; a_faddr = addr; tick(); a_freq = 1'b0;
  endtask

  task automatic a_reset();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
  endtask

  logic [31:0] prog [7];

  initial begin
    prog[0] = 32'h04010005; prog[1] = 32'h04020003; prog[2] = 32'h00221820;
    prog[3] = 32'h0C030001; prog[4] = 32'hAC030010; prog[5] = 32'h8C040010;
    prog[6] = 32'h4FE00000;

    // ---- reset state ----
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
    chk("rst_cnt",   32'(a_cnt),   32'd0);
    chk("rst_ready", 32'(a_ready), 32'd1);
    chk("rst_run",   32'(a_run),   32'd0);
    chk("rst_fv",    32'(a_fv),    32'd0);
    chk("rst_instr", a_instr,      32'h0);
    chk("rst_fault", 32'(a_fault), 32'd0);
    chk("rst_halt",  32'(a_halt),  32'd0);

    // ---- fetch during LOAD is ignored ----
    a_fetch(32'h0);
    chk("load_fetch_fv", 32'(a_fv), 32'd0);

    // ---- load 7 words then LoadDone ----
    for (int i = 0; i < 7; i++) a_load(prog[i]);
    chk("load7_cnt", 32'(a_cnt), 32'd7);
    chk("load7_run", 32'(a_run), 32'd0);
    a_done = 1'b1; tick(); a_done = 1'b0;
    chk("done_run",   32'(a_run),   32'd1);
    chk("done_cnt",   32'(a_cnt),   32'd7);
    chk("done_ready", 32'(a_ready), 32'd0);

    // ---- back-to-back fetches, then idle hold ----
    a_fetch(32'h0);
    chk("f0_fv",    32'(a_fv), 32'd1);
    chk("f0_instr", a_instr,   32'h04010005);
    a_fetch(32'h18);
    chk("f18_fv",    32'(a_fv), 32'd1);
    chk("f18_instr", a_instr,   32'h4FE00000);
    tick();
    chk("idle_fv",    32'(a_fv), 32'd0);
    chk("idle_instr", a_instr,   32'h4FE00000);
    chk("idle_fault", 32'(a_fault), 32'd0);

    // ---- load port ignored in RUN ----
    a_lv = 1'b1; a_ld = 32'hDEADBEEF; a_done = 1'b1; tick(); a_lv = 1'b0; a_done = 1'b0;
    chk("run_load_cnt", 32'(a_cnt), 32'd7);

    // ---- invalid addresses ----
    a_fetch(32'h1C);
    chk("f1c_fv",    32'(a_fv),    32'd1);
    chk("f1c_instr", a_instr,      32'h0);
    chk("f1c_fault", 32'(a_fault), 32'd1);
    a_fetch(32'h102);
    chk("f102_instr", a_instr,      32'h0);
    chk("f102_fv",    32'(a_fv),    32'd1);
    a_fetch(32'h400);
    chk("f400_instr", a_instr,      32'h0);
    chk("f400_fv",    32'(a_fv),    32'd1);
    a_fetch(32'h4);
    chk("f4_instr", a_instr,      32'h04020003);
    chk("f4_fault", 32'(a_fault), 32'd1);

    // ---- reset mid-load, then short reload ----
    a_reset();
    chk("rr_fault", 32'(a_fault), 32'd0);
    a_load(32'h11111111); a_load(32'h22222222); a_load(32'h33333333);
    chk("ml_cnt", 32'(a_cnt), 32'd3);
    a_reset();
    chk("ml_rst_cnt",   32'(a_cnt),   32'd0);
    chk("ml_rst_ready", 32'(a_ready), 32'd1);
    a_load(32'h55555555); a_load(32'h66666666);
    a_done = 1'b1; tick(); a_done = 1'b0;
    a_fetch(32'h8);
    chk("rl_f8_instr", a_instr,      32'h0);
    chk("rl_f8_fault", 32'(a_fault), 32'd1);
    a_fetch(32'h4);
    chk("rl_f4_instr", a_instr, 32'h66666666);

    // ---- halt detection ----
    a_reset();
    a_load(32'h11111111); a_load(32'h22222222); a_load(32'hFFFFFFFF);
    a_done = 1'b1; tick(); a_done = 1'b0;
    a_fetch(32'h8);
    chk("h_f8_instr", a_instr,     32'hFFFFFFFF);
    chk("h_f8_halt",  32'(a_halt), 32'd1);
    a_fetch(32'h0);
    chk("h_f0_instr", a_instr,      32'h0);
    chk("h_f0_fv",    32'(a_fv),    32'd1);
    a_fetch(32'h400);
    chk("h_bad_fault", 32'(a_fault), 32'd0);
    chk("h_bad_halt",  32'(a_halt),  32'd1);

    // ---- DEPTH=4: auto-RUN on the last slot ----
    b_lv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b_ld = 32'hA0 + 32'(i);
      tick();
    end
    chk("b_ready", 32'(b_ready), 32'd0);
    chk("b_run",   32'(b_run),   32'd1);
    chk("b_cnt",   32'(b_cnt),   32'd4);
    b_ld = 32'h00000BAD; tick(); b_lv = 1'b0;
    chk("b_5th_cnt", 32'(b_cnt), 32'd4);
    b_freq = 1'b1; b_faddr = 32'hC; tick(); b_freq = 1'b0;
    chk("b_fc_instr", b_instr, 32'hA3);
    b_freq = 1'b1; b_faddr = 32'h10; tick(); b_freq = 1'b0;
    chk("b_f10_instr", b_instr,      32'h0);
    chk("b_f10_fault", 32'(b_fault), 32'd1);

    // ---- word-addressed fetch ----
    c_freq = 1'b1; c_faddr = 32'd0; tick(); c_freq = 1'b0;
    chk("c_load_fv", 32'(c_fv), 32'd0);
    c_lv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      c_ld = 32'hC0 + 32'(i);
      tick();
    end
    c_lv = 1'b0;
    c_done = 1'b1; tick(); c_done = 1'b0;
    c_freq = 1'b1; c_faddr = 32'd3; tick(); c_freq = 1'b0;
    chk("c_i3_instr", c_instr,      32'hC3);
    chk("c_i3_fault", 32'(c_fault), 32'd0);
    c_freq = 1'b1; c_faddr = 32'd4; tick(); c_freq = 1'b0;
    chk("c_i4_instr", c_instr,      32'h0);
    chk("c_i4_fault", 32'(c_fault), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
